// File: rtl/nphy_toggle_physical_output_ddr100.sv
// ---------------------------------------------------------------------------
// nphy_toggle_physical_output_ddr100
//
// Write-path PHY for a toggle-mode NAND interface. This block is the transmit
// counterpart of the DQS-captured DDR input PHY. It takes 32-bit words from the
// channel controller into a small FIFO and serialises them to the NAND at one
// byte per clock.
//
// iSystemClock runs at twice the DQS toggle rate. A 200 MHz clock therefore
// produces a 100 MHz DQS with DDR data. DQS leaves this block edge-aligned to
// DQ. The 90-degree shift that centre-aligns DQS is done by the pad delay
// outside this block.
//
// Burst shape on the pads:
//   PREAMBLE  : both OEs on, DQS low, for PreambleCycles clocks. The preamble
//               stretches while no data is available.
//   DATA      : one byte per clock. DQS is high on even beats and low on odd
//               beats.
//   POSTAMBLE : DQS low and DQ holding the last byte, for PostambleCycles
//               clocks. After that both OEs drop and oPO_Done pulses.
//
// Parameters
//   FifoDepthLog2    FIFO depth is 2**FifoDepthLog2 words of 32 bit
//   PreambleCycles   DQS-low clocks before the first rising edge (1..15)
//   PostambleCycles  DQS-low clocks after the last falling edge  (1..15)
//
// Ports
//   iSystemClock     single clock for all logic
//   iModuleReset_n   asynchronous, active-low reset
//   iPO_Start        one-cycle burst start pulse; sampled only in IDLE
//   iPO_ByteCount    burst length in bytes; the LSB is ignored
//   iPO_Flush        clears the FIFO; honoured only in IDLE
//   iPO_Data         write word; [7:0] is sent first and [31:24] last
//   iPO_Valid        iPO_Data is valid
//   oPO_Ready        FIFO is not full
//   oPO_Busy         a burst is in progress
//   oPO_Done         one-cycle pulse when the burst returns to IDLE
//   oPO_Stall        the burst is paused waiting for FIFO data
//   oDQToNAND        DQ to the pad
//   oDQOE            DQ output enable
//   oDQSToNAND       DQS to the pad
//   oDQSOE           DQS output enable
// ---------------------------------------------------------------------------
module nphy_toggle_physical_output_ddr100 #(
   parameter int FifoDepthLog2   = 2,
   parameter int PreambleCycles  = 2,
   parameter int PostambleCycles = 2
) (
   input  logic        iSystemClock,
   input  logic        iModuleReset_n,
   input  logic        iPO_Start,
   input  logic [15:0] iPO_ByteCount,
   input  logic        iPO_Flush,
   input  logic [31:0] iPO_Data,
   input  logic        iPO_Valid,
   output logic        oPO_Ready,
   output logic        oPO_Busy,
   output logic        oPO_Done,
   output logic        oPO_Stall,
   output logic [7:0]  oDQToNAND,
   output logic        oDQOE,
   output logic        oDQSToNAND,
   output logic        oDQSOE
);

   localparam int                       FifoDepth  = 1 << FifoDepthLog2;
   localparam logic [FifoDepthLog2:0]   cFifoFull  = (FifoDepthLog2+1)'(FifoDepth);
   localparam logic [FifoDepthLog2:0]   cCountOne  = (FifoDepthLog2+1)'(1);
   localparam logic [FifoDepthLog2-1:0] cPtrOne    = (FifoDepthLog2)'(1);
   localparam logic [3:0]               cPreamble  = 4'(PreambleCycles);
   localparam logic [3:0]               cPostamble = 4'(PostambleCycles);

   typedef enum logic [1:0] {
      sIdle,
      sPreamble,
      sData,
      sPostamble
   } tPhyState;

   // -----------------------------------------------------------------------
   // Byte lane selection within the current word
   // -----------------------------------------------------------------------
   function automatic logic [7:0] selectByte(input logic [31:0] word,
                                             input logic [1:0]  lane);
      logic [7:0] result;
      case (lane)
         2'd0:    result = word[7:0];
         2'd1:    result = word[15:8];
         2'd2:    result = word[23:16];
         default: result = word[31:24];
      endcase
      return result;
   endfunction

   // -----------------------------------------------------------------------
   // Write-data FIFO
   // -----------------------------------------------------------------------
   logic [31:0]              rFifoMem [FifoDepth];
   logic [FifoDepthLog2-1:0] rWritePtr;
   logic [FifoDepthLog2-1:0] rReadPtr;
   logic [FifoDepthLog2:0]   rFifoCount;
   logic                     rReadyEnable;

   logic                     wFifoFull;
   logic                     wFifoEmpty;
   logic                     wFlush;
   logic                     wPush;
   logic                     wPop;
   logic                     wWordAvailable;
   logic [31:0]              wHeadWord;

   tPhyState                 rState;
   tPhyState                 wNextState;

   assign wFifoFull  = (rFifoCount == cFifoFull);
   assign wFifoEmpty = (rFifoCount == '0);

   // Ready stays low through reset and rises on the first clock after release.
   assign oPO_Ready  = rReadyEnable & ~wFifoFull;
   assign wFlush     = iPO_Flush & (rState == sIdle);
   assign wPush      = iPO_Valid & oPO_Ready & ~wFlush;

   // A word arriving while the FIFO is empty is forwarded straight into the
   // DQ register. The burst then resumes on the cycle after the push. Both
   // pointers advance together in that case, so the FIFO stays empty.
   assign wWordAvailable = ~wFifoEmpty | wPush;
   assign wHeadWord      = wFifoEmpty ? iPO_Data : rFifoMem[rReadPtr];

   always_ff @(posedge iSystemClock or negedge iModuleReset_n) begin
      if (!iModuleReset_n) begin
         rWritePtr    <= '0;
         rReadPtr     <= '0;
         rFifoCount   <= '0;
         rReadyEnable <= 1'b0;
      end else begin
         rReadyEnable <= 1'b1;
         if (wFlush) begin
            rWritePtr  <= '0;
            rReadPtr   <= '0;
            rFifoCount <= '0;
         end else begin
            if (wPush) begin
               rWritePtr <= rWritePtr + cPtrOne;
            end
            if (wPop) begin
               rReadPtr <= rReadPtr + cPtrOne;
            end
            case ({wPush, wPop})
               2'b10:   rFifoCount <= rFifoCount + cCountOne;
               2'b01:   rFifoCount <= rFifoCount - cCountOne;
               default: rFifoCount <= rFifoCount;
            endcase
         end
      end
   end

   always_ff @(posedge iSystemClock) begin
      if (wPush) begin
         rFifoMem[rWritePtr] <= iPO_Data;
      end
   end

   // -----------------------------------------------------------------------
   // Burst sequencer
   // -----------------------------------------------------------------------
   logic [15:0] rByteCount;
   logic [15:0] wNextByteCount;
   logic [15:0] rBeatCount;       // beats already driven in this burst
   logic [15:0] wNextBeatCount;
   logic [3:0]  rAmbleCount;      // pre/postamble clocks already driven
   logic [3:0]  wNextAmbleCount;
   logic [31:0] rCurrentWord;
   logic [31:0] wNextCurrentWord;
   logic [15:0] wStartLength;

   logic [7:0]  rDQ;
   logic [7:0]  wNextDQ;
   logic        rDQS;
   logic        wNextDQS;
   logic        rOutputEnable;
   logic        wNextOutputEnable;
   logic        rDone;
   logic        wNextDone;
   logic        rStall;
   logic        wNextStall;

   // Clearing the LSB rounds the length down to an even number of bytes.
   assign wStartLength = iPO_ByteCount & 16'hFFFE;

   always_comb begin
      wNextState        = rState;
      wNextByteCount    = rByteCount;
      wNextBeatCount    = rBeatCount;
      wNextAmbleCount   = rAmbleCount;
      wNextCurrentWord  = rCurrentWord;
      wNextDQ           = rDQ;
      wNextDQS          = 1'b0;
      wNextOutputEnable = 1'b0;
      wNextDone         = 1'b0;
      wNextStall        = 1'b0;
      wPop              = 1'b0;

      case (rState)
         sIdle: begin
            wNextDQ = 8'h00;
            if (iPO_Start) begin
               if (wStartLength == 16'd0) begin
                  wNextDone = 1'b1;
               end else begin
                  wNextState        = sPreamble;
                  wNextByteCount    = wStartLength;
                  wNextBeatCount    = 16'd0;
                  wNextAmbleCount   = 4'd1;
                  wNextOutputEnable = 1'b1;
               end
            end
         end

         sPreamble: begin
            wNextOutputEnable = 1'b1;
            wNextDQ           = 8'h00;
            if (rAmbleCount >= cPreamble) begin
               // The minimum preamble is done. Start data, or stretch the
               // preamble while the FIFO has nothing to send.
               if (wWordAvailable) begin
                  wPop             = 1'b1;
                  wNextCurrentWord = wHeadWord;
                  wNextDQ          = wHeadWord[7:0];
                  wNextDQS         = 1'b1;
                  wNextBeatCount   = 16'd1;
                  wNextState       = sData;
               end else begin
                  wNextStall = 1'b1;
               end
            end else begin
               wNextAmbleCount = rAmbleCount + 4'd1;
            end
         end

         sData: begin
            wNextOutputEnable = 1'b1;
            if (rBeatCount == rByteCount) begin
               // The last beat was odd, so DQS is already low here.
               wNextState      = sPostamble;
               wNextAmbleCount = 4'd1;
            end else if (rBeatCount[1:0] == 2'd0) begin
               if (wWordAvailable) begin
                  wPop             = 1'b1;
                  wNextCurrentWord = wHeadWord;
                  wNextDQ          = wHeadWord[7:0];
                  wNextDQS         = 1'b1;
                  wNextBeatCount   = rBeatCount + 16'd1;
               end else begin
                  // Underrun: DQS is held low and DQ keeps byte3.
                  wNextStall = 1'b1;
               end
            end else begin
               wNextDQ        = selectByte(rCurrentWord, rBeatCount[1:0]);
               wNextDQS       = ~rBeatCount[0];
               wNextBeatCount = rBeatCount + 16'd1;
            end
         end

         sPostamble: begin
            if (rAmbleCount >= cPostamble) begin
               wNextState = sIdle;
               wNextDone  = 1'b1;
               wNextDQ    = 8'h00;
            end else begin
               wNextOutputEnable = 1'b1;
               wNextAmbleCount   = rAmbleCount + 4'd1;
            end
         end

         default: begin
            wNextState = sIdle;
            wNextDQ    = 8'h00;
         end
      endcase
   end

   always_ff @(posedge iSystemClock or negedge iModuleReset_n) begin
      if (!iModuleReset_n) begin
         rState        <= sIdle;
         rByteCount    <= 16'd0;
         rBeatCount    <= 16'd0;
         rAmbleCount   <= 4'd0;
         rDQ           <= 8'h00;
         rDQS          <= 1'b0;
         rOutputEnable <= 1'b0;
         rDone         <= 1'b0;
         rStall        <= 1'b0;
      end else begin
         rState        <= wNextState;
         rByteCount    <= wNextByteCount;
         rBeatCount    <= wNextBeatCount;
         rAmbleCount   <= wNextAmbleCount;
         rDQ           <= wNextDQ;
         rDQS          <= wNextDQS;
         rOutputEnable <= wNextOutputEnable;
         rDone         <= wNextDone;
         rStall        <= wNextStall;
      end
   end

   always_ff @(posedge iSystemClock) begin
      rCurrentWord <= wNextCurrentWord;
   end

   // -----------------------------------------------------------------------
   // Outputs (all pad signals come straight from flops)
   // -----------------------------------------------------------------------
   assign oDQToNAND  = rDQ;
   assign oDQOE      = rOutputEnable;
   assign oDQSToNAND = rDQS;
   assign oDQSOE     = rOutputEnable;
   assign oPO_Done   = rDone;
   assign oPO_Stall  = rStall;
   assign oPO_Busy   = (rState != sIdle);

endmodule

// File: tb/tb_nphy_toggle_physical_output_ddr100.sv
module tb_nphy_toggle_physical_output_ddr100;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] byteCount;
   logic        flush;
   logic [31:0] data;
   logic        valid;
   logic        ready;
   logic        busy;
   logic        done;
   logic        stall;
   logic [7:0]  dq;
   logic        dqOE;
   logic        dqs;
   logic        dqsOE;

   int total = 0;
   int bad   = 0;

   nphy_toggle_physical_output_ddr100 dut (
      .iSystemClock   (clk),
      .iModuleReset_n (rst_n),
      .iPO_Start      (start),
      .iPO_ByteCount  (byteCount),
      .iPO_Flush      (flush),
      .iPO_Data       (data),
      .iPO_Valid      (valid),
      .oPO_Ready      (ready),
      .oPO_Busy       (busy),
      .oPO_Done       (done),
      .oPO_Stall      (stall),
      .oDQToNAND      (dq),
      .oDQOE          (dqOE),
      .oDQSToNAND     (dqs),
      .oDQSOE         (dqsOE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One record per clock: the inputs driven during that cycle and the
   // outputs expected during that same cycle.
   typedef struct {
      logic        start;
      logic [15:0] bc;
      logic        flush;
      logic        valid;
      logic [31:0] data;
      logic [7:0]  dq;
      logic        oe;
      logic        dqs;
      logic        busy;
      logic        done;
      logic        stall;
      logic        ready;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
      end
   endtask

   task automatic v(input int st, input int bc, input int fl, input int va, input logic [31:0] d,
                    input int edq, input int eoe, input int edqs, input int ebz, input int edn,
                    input int esl, input int erd);
      vec_t r;
      r.start = st[0];  r.bc = bc[15:0];  r.flush = fl[0];  r.valid = va[0];  r.data = d;
      r.dq = edq[7:0];  r.oe = eoe[0];    r.dqs = edqs[0];  r.busy = ebz[0];
      r.done = edn[0];  r.stall = esl[0]; r.ready = erd[0];
      tbl.push_back(r);
   endtask

   // Shorthands for common rows.
   task automatic idle(input int dn);            v(0, 0, 0, 0, 0, 0, 0, 0, 0, dn, 0, 1); endtask
   task automatic push(input logic [31:0] d);    v(0, 0, 0, 1, d, 0, 0, 0, 0, 0, 0, 1); endtask
   task automatic pre(input int sl);             v(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, sl, 1); endtask
   task automatic beat(input int b, input int s); v(0, 0, 0, 0, 0, b, 1, s, 1, 0, 0, 1); endtask

   task automatic run(input string nm, input int limit);
      int n;
      n = (limit < 0) ? tbl.size() : limit;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         start     = tbl[i].start;
         byteCount = tbl[i].bc;
         flush     = tbl[i].flush;
         valid     = tbl[i].valid;
         data      = tbl[i].data;
         chk($sformatf("%s[%0d].pads", nm, i), {21'd0, dq, dqOE, dqs, dqsOE},
             {21'd0, tbl[i].dq, tbl[i].oe, tbl[i].dqs, tbl[i].oe});
         chk($sformatf("%s[%0d].ctl", nm, i), {28'd0, busy, done, stall, ready},
             {28'd0, tbl[i].busy, tbl[i].done, tbl[i].stall, tbl[i].ready});
      end
   endtask

   task automatic build_s1();
      tbl.delete();
      push(32'h44332211);
      v(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      pre(0); pre(0);
      beat('h11, 1); beat('h22, 0); beat('h33, 1); beat('h44, 0);
      beat('h44, 0); beat('h44, 0);
      idle(1); idle(0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; byteCount = '0; flush = 1'b0; data = '0; valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.pads", {21'd0, dq, dqOE, dqs, dqsOE}, 32'd0);
      chk("reset.ctl", {28'd0, busy, done, stall, ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic 4-byte burst from a prefilled FIFO.
      build_s1();
      run("s1", -1);

      // 6-byte burst: bytes 07/08 of the second word are dropped.
      tbl.delete();
      push(32'h04030201); push(32'h08070605);
      v(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      pre(0); pre(0);
      beat('h01, 1); beat('h02, 0); beat('h03, 1); beat('h04, 0);
      beat('h05, 1); beat('h06, 0); beat('h06, 0); beat('h06, 0);
      idle(1);
      run("s2", -1);

      // Fill to full, flush (and flush beating a push), zero-length starts.
      // A full FIFO after exactly four pushes also shows s2 left it empty.
      tbl.delete();
      push(32'hA0A0A0A0); push(32'hB0B0B0B0); push(32'hC0C0C0C0); push(32'hD0D0D0D0);
      v(0, 0, 0, 1, 32'hE0E0E0E0, 0, 0, 0, 0, 0, 0, 0);
      v(0, 0, 1, 0, 0,            0, 0, 0, 0, 0, 0, 0);
      v(0, 0, 1, 1, 32'hF0F0F0F0, 0, 0, 0, 0, 0, 0, 1);
      v(1, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 1);
      v(1, 1, 0, 0, 0,            0, 0, 0, 0, 1, 0, 1);
      idle(1); idle(0);
      run("s5", -1);

      // Start with an empty FIFO: preamble stretches until a word arrives.
      tbl.delete();
      v(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      pre(0); pre(0); pre(1); pre(1);
      v(0, 0, 0, 1, 32'h87654321, 0, 1, 0, 1, 0, 1, 1);
      beat('h21, 1); beat('h43, 0); beat('h65, 1); beat('h87, 0);
      beat('h87, 0); beat('h87, 0);
      idle(1);
      run("s3", -1);

      // 8-byte burst with a mid-burst underrun of three cycles.
      tbl.delete();
      push(32'h14131211);
      v(1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      pre(0); pre(0);
      beat('h11, 1); beat('h12, 0); beat('h13, 1); beat('h14, 0);
      v(0, 0, 0, 0, 0,            'h14, 1, 0, 1, 0, 1, 1);
      v(0, 0, 0, 0, 0,            'h14, 1, 0, 1, 0, 1, 1);
      v(0, 0, 0, 1, 32'h18171615, 'h14, 1, 0, 1, 0, 1, 1);
      beat('h15, 1); beat('h16, 0); beat('h17, 1); beat('h18, 0);
      beat('h18, 0); beat('h18, 0);
      idle(1); idle(0);
      run("s4", -1);

      // Reset asserted asynchronously while byte 0x33 (beat 2) is on the pads.
      build_s1();
      run("s6a", 7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("s6.rst.pads", {21'd0, dq, dqOE, dqs, dqsOE}, 32'd0);
      chk("s6.rst.ctl", {28'd0, busy, done, stall, ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("s6.release.ctl", {28'd0, busy, done, stall, ready}, 32'd1);
      build_s1();
      run("s6b", -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
